// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - steps an 8:1 mux select, samples each channel after a settle delay, emits an 8-bit word
module mux_scan_sampler #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic [2:0] sel,
  input  logic       mux_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Channels 0..6 only; channel 7 goes straight from mux_in into the output word.
  logic [6:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;

  // Next-state logic: settle countdown, per-channel capture, word hand-off.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d = SETTLE;
          cnt_d   = RELOAD;
          shreg_d = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sel_q != 3'd7) begin
          // shreg is cleared at scan start, so OR-ing in the bit is a plain write.
          shreg_d = shreg_q | (7'(mux_in) << sel_q);
          sel_d   = sel_q + 3'd1;
          cnt_d   = RELOAD;
        end else begin
          data_d  = {mux_in, shreg_q};
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (data_ready) begin
          valid_d = 1'b0;
          sel_d   = 3'd0;
          if (cont) begin
            state_d = SETTLE;
            cnt_d   = RELOAD;
            shreg_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign sel        = sel_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed vector bench for mux_scan_sampler
module tb_mux_scan_sampler;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, data_ready, data_valid, busy, mux_in;
  logic [2:0] sel;
  logic [7:0] data_out, d_pat;

  logic       start0, cont0, ready0, valid0, busy0, mux_in0;
  logic [2:0] sel0;
  logic [7:0] data_out0, d_pat0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural 8:1 mux feeding each sampler.
  assign mux_in  = d_pat[sel];
  assign mux_in0 = d_pat0[sel0];

  mux_scan_sampler #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sel(sel),
    .mux_in(mux_in), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy)
  );

  mux_scan_sampler #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .sel(sel0),
    .mux_in(mux_in0), .data_out(data_out0), .data_valid(valid0),
    .data_ready(ready0), .busy(busy0)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         ready_wait;
    int         glitch;
    logic [7:0] exp;
  } vec_t;

  // Single-shot scan on the SETTLE_CYCLES=2 instance: latency, sel sequence, word, hold, handshake.
  task automatic run_scan(input logic [7:0] d, input int rw, input int gl,
                          input logic [7:0] exp, input string tag);
    int k;
    bit sel_ok, hold_ok, quiet_ok;
    d_pat      = d;
    cont       = 1'b0;
    data_ready = (rw == 0);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    k = 0;
    sel_ok = 1'b1;
    while (!data_valid && k < 100) begin
      if (sel !== 3'(k / 3)) sel_ok = 1'b0;
      start = (gl != 0 && k == gl);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, k, 24);
    chk({tag, "_sel_seq"}, sel_ok, 1);
    chk({tag, "_word"}, data_out, exp);
    chk({tag, "_sel7"}, sel, 7);
    if (rw > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < rw; i++) begin
        @(negedge clk);
        if (data_valid !== 1'b1 || data_out !== exp || sel !== 3'd7 || busy !== 1'b1)
          hold_ok = 1'b0;
      end
      chk({tag, "_hold"}, hold_ok, 1);
    end
    data_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, data_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_sel"}, sel, 0);
    chk({tag, "_word_kept"}, data_out, exp);
    if (gl != 0) begin
      quiet_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (data_valid !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
      end
      chk({tag, "_one_word"}, quiet_ok, 1);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int  k, p;
    bit  ok;
    vecs[0] = '{d: 8'hA5, ready_wait: 0,  glitch: 0, exp: 8'hA5};
    vecs[1] = '{d: 8'hA5, ready_wait: 10, glitch: 0, exp: 8'hA5};
    vecs[2] = '{d: 8'h5A, ready_wait: 3,  glitch: 0, exp: 8'h5A};
    vecs[3] = '{d: 8'hF0, ready_wait: 0,  glitch: 5, exp: 8'hF0};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; data_ready = 1'b1; d_pat = 8'h00;
    start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b1; d_pat0 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst0_valid", valid0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_scan(vecs[i].d, vecs[i].ready_wait, vecs[i].glitch, vecs[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset mid-scan while sel==4, then a fresh scan with no stale bits.
    d_pat = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstmid_sel4", sel, 4);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sel", sel, 0);
    chk("rstmid_valid", data_valid, 0);
    chk("rstmid_data", data_out, 8'h00);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(8'h60, 0, 0, 8'h60, "fresh");

    // Continuous mode: two back-to-back words with a 25-cycle valid period.
    d_pat = 8'h3C; cont = 1'b1; data_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!data_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cont_lat1", k, 24);
    chk("cont_word1", data_out, 8'h3C);
    d_pat = 8'hC3;
    @(negedge clk);
    cont = 1'b0;
    p = 1;
    ok = busy;
    while (!data_valid && p < 100) begin
      @(negedge clk);
      p++;
      if (busy !== 1'b1) ok = 1'b0;
    end
    chk("cont_period", p, 25);
    chk("cont_word2", data_out, 8'hC3);
    chk("cont_busy", ok, 1);
    @(negedge clk);
    chk("cont_end_busy", busy, 0);

    // SETTLE_CYCLES=0: sel advances every cycle, valid 8 cycles after start.
    d_pat0 = 8'h81; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    ok = 1'b1;
    while (!valid0 && k < 100) begin
      if (sel0 !== 3'(k)) ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("s0_latency", k, 8);
    chk("s0_sel_seq", ok, 1);
    chk("s0_word", data_out0, 8'h81);
    @(negedge clk);
    chk("s0_idle", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
